// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional multiply-accumulate (MADD/MSUB) is enabled by defining MULDIV_ACCUMULATE_EN.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [2*WIDTH-1:0] acc_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               div_by_zero_o
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W2-1:0]   work_q, work_d;
  logic [W2-1:0]   mcand_q, mcand_d;
  logic [W2-1:0]   result_q, result_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            dbz_q, dbz_d;

  logic [2:0]      op_eff;
  logic            is_div, is_uns, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [W2-1:0]   prod_nxt, prod_sgn, mul_res;
  logic [WIDTH:0]  shifted, diff;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [W2-1:0]   div_res;

`ifdef MULDIV_ACCUMULATE_EN
  logic [W2-1:0]   acc_q, acc_d;
  logic            accum_q, accum_d, sub_q, sub_d;
  assign op_eff  = op_i;
  assign mul_res = accum_q ? (sub_q ? acc_q - prod_sgn : acc_q + prod_sgn) : prod_sgn;
`else
  logic            unused_cfg;
  assign unused_cfg = ^{op_i[2], acc_i};
  assign op_eff  = {1'b0, op_i[1:0]};
  assign mul_res = prod_sgn;
`endif

  // 11x is MSUB when accumulate is enabled, so divide requires op[2]==0
  assign is_div = op_eff[1] & ~op_eff[2];
  assign is_uns = op_eff[0];
  assign a_neg  = ~is_uns & a_i[WIDTH-1];
  assign b_neg  = ~is_uns & b_i[WIDTH-1];
  assign a_mag  = a_neg ? -a_i : a_i;
  assign b_mag  = b_neg ? -b_i : b_i;

  assign prod_nxt = work_q + (opb_q[0] ? mcand_q : '0);
  assign prod_sgn = qneg_q ? -prod_nxt : prod_nxt;

  // work_q holds {remainder, dividend/quotient} during a divide
  assign shifted = {work_q[W2-1:WIDTH], work_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, opb_q};
  assign rem_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_nxt = {work_q[WIDTH-2:0], ~diff[WIDTH]};
  assign div_res = {(rneg_q ? -rem_nxt : rem_nxt), (qneg_q ? -quo_nxt : quo_nxt)};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    mcand_d  = mcand_q;
    opb_d    = opb_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    dbz_d    = dbz_q;
`ifdef MULDIV_ACCUMULATE_EN
    acc_d    = acc_q;
    accum_d  = accum_q;
    sub_d    = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          cnt_d   = CW'(WIDTH - 1);
          opb_d   = b_mag;
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          mcand_d = {{WIDTH{1'b0}}, a_mag};
`ifdef MULDIV_ACCUMULATE_EN
          acc_d   = acc_i;
          accum_d = op_eff[2];
          sub_d   = op_eff[1];
`endif
          if (is_div) begin
            work_d  = {{WIDTH{1'b0}}, a_mag};
            state_d = DIV;
          end else begin
            work_d  = '0;
            state_d = MUL;
          end
        end
      end
      MUL: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          work_d  = prod_nxt;
          mcand_d = mcand_q << 1;
          opb_d   = opb_q >> 1;
          if (cnt_q == '0) begin
            state_d  = DONE;
            result_d = mul_res;
            dbz_d    = 1'b0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      DIV: begin
        if (annul_i) begin
          state_d = IDLE;
        end else if (opb_q == '0) begin
          state_d  = DONE;
          result_d = '0;
          dbz_d    = 1'b1;
          cnt_d    = '0;
        end else begin
          work_d = {rem_nxt, quo_nxt};
          if (cnt_q == '0) begin
            state_d  = DONE;
            result_d = div_res;
            dbz_d    = 1'b0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      mcand_q  <= '0;
      opb_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
`ifdef MULDIV_ACCUMULATE_EN
      acc_q    <= '0;
      accum_q  <= 1'b0;
      sub_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      mcand_q  <= mcand_d;
      opb_q    <= opb_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
`ifdef MULDIV_ACCUMULATE_EN
      acc_q    <= acc_d;
      accum_q  <= accum_d;
      sub_q    <= sub_d;
`endif
    end
  end

  assign busy_o        = (state_q != IDLE);
  assign ready_o       = (state_q == DONE);
  assign result_o      = result_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic/latency reference model plus directed literal cases.
module tb_muldiv_unit;
  localparam int W = 32;
`ifdef MULDIV_ACCUMULATE_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, annul = 1'b0;
  logic [2:0] op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic [2*W-1:0] acc = '0;
  logic busy, ready, dbz;
  logic [2*W-1:0] result;

  int n_cmp = 0, n_bad = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .annul_i(annul), .op_i(op),
    .a_i(a), .b_i(b), .acc_i(acc), .busy_o(busy), .ready_o(ready),
    .result_o(result), .div_by_zero_o(dbz)
  );

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference arithmetic straight from the operation definitions.
  function automatic void model_calc(input logic [2:0] o_in, input logic [31:0] x, input logic [31:0] y,
                                     input logic [63:0] c, output logic [63:0] res,
                                     output bit zdiv);
    logic [2:0] o;
    longint sx, sy, q, r;
    logic [63:0] p;
    o = o_in;
    if (!ACC) o[2] = 1'b0;
    sx = $signed(x);
    sy = $signed(y);
    zdiv = 1'b0;
    if (!o[2] && o[1]) begin
      if (y == 0) begin
        res = '0;
        zdiv = 1'b1;
      end else if (o[0]) begin
        res = {x % y, x / y};
      end else begin
        q = sx / sy;
        r = sx % sy;
        res = {r[31:0], q[31:0]};
      end
    end else begin
      if (o[0]) p = {32'b0, x} * {32'b0, y};
      else      p = sx * sy;
      if (o[2]) res = o[1] ? c - p : c + p;
      else      res = p;
    end
  endfunction

  // Latency model: accepted op completes WIDTH edges later (1 edge for divide by zero).
  int m_phase = 0, m_rem = 0;
  logic [63:0] m_res = '0, p_res;
  bit m_dbz = 1'b0, p_dbz;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_rem = 0; m_res = '0; m_dbz = 1'b0;
    end else begin
      case (m_phase)
        0: if (start && !annul) begin
             model_calc(op, a, b, acc, p_res, p_dbz);
             m_rem = p_dbz ? 1 : W;
             m_phase = 1;
           end
        1: if (annul) m_phase = 0;
           else begin
             m_rem--;
             if (m_rem == 0) begin
               m_phase = 2; m_res = p_res; m_dbz = p_dbz;
             end
           end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    check("busy", busy, 64'(m_phase != 0));
    check("ready", ready, 64'(m_phase == 2));
    check("result", result, m_res);
    check("dbz", dbz, 64'(m_dbz));
  end

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 3 * W) begin
      @(negedge clk);
      k++;
    end
    check("idle_wait", busy, 0);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] c, output int lat);
    int k;
    wait_idle();
    @(posedge clk); #1;
    op = o; a = x; b = y; acc = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    @(negedge clk);
    while (!ready && k < W + 4) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    lat = ready ? k : -1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(15));
      5: return -32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] r;
    bit d;
    int lat, t0, t1;
    bit prev, saw;

    model_calc(3'b000, 32'hFFFF_FFFE, 32'd3, 64'h0, r, d);
    check("model_mult", r, 64'hFFFF_FFFF_FFFF_FFFA);
    model_calc(3'b010, 32'hFFFF_FFF9, 32'd2, 64'h0, r, d);
    check("model_div", r, 64'hFFFF_FFFF_FFFF_FFFD);
    model_calc(3'b011, 32'd5, 32'd0, 64'h0, r, d);
    check("model_dbz", 64'(d), 64'd1);
    model_calc(3'b100, 32'd4, 32'd5, 64'h10, r, d);
    check("model_madd", r, ACC ? 64'h24 : 64'h14);

    @(negedge clk);
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_op(3'b000, 32'hFFFF_FFFE, 32'd3, 64'h0, lat);
    check("mult_lat", lat, 32);
    check("mult_res", result, 64'hFFFF_FFFF_FFFF_FFFA);

    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, 64'h0, lat);
    check("div_res", result, 64'hFFFF_FFFF_FFFF_FFFD);
    check("div_dbz", dbz, 0);

    run_op(3'b011, 32'd5, 32'd0, 64'h0, lat);
    check("dbz_lat", lat, 1);
    check("dbz_res", result, 0);
    check("dbz_flag", dbz, 1);

    run_op(3'b001, 32'd2, 32'd3, 64'h0, lat);
    check("multu_res", result, 64'd6);
    check("multu_dbz", dbz, 0);

    wait_idle();
    @(posedge clk); #1;
    op = 3'b001; a = 32'd7; b = 32'd9; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 annul = 1'b1;
    @(posedge clk); #1 annul = 1'b0;
    @(negedge clk);
    check("annul_busy", busy, 0);
    saw = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      if (ready) saw = 1'b1;
    end
    check("annul_noready", 64'(saw), 0);
    check("annul_result", result, 64'd6);

    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0, lat);
    check("minneg_res", result, 64'h0000_0000_8000_0000);
    check("minneg_dbz", dbz, 0);

    run_op(3'b100, 32'd4, 32'd5, 64'h10, lat);
    check("madd_res", result, ACC ? 64'h24 : 64'h14);

    wait_idle();
    @(posedge clk); #1;
    op = 3'b001; a = 32'd3; b = 32'd3; start = 1'b1;
    t0 = -1; t1 = -1; prev = 1'b0;
    for (int k = 0; k < 3 * W && t1 < 0; k++) begin
      @(negedge clk);
      if (busy && !prev) begin
        if (t0 < 0) t0 = cyc;
        else        t1 = cyc;
      end
      prev = busy;
    end
    @(posedge clk); #1 start = 1'b0;
    check("b2b_interval", t1 - t0, W + 2);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst   = ($urandom_range(599) == 0);
      start = ($urandom_range(3) != 0);
      annul = ($urandom_range(49) == 0);
      op    = 3'($urandom);
      a     = pick();
      b     = pick();
      acc   = {$urandom, $urandom};
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; annul = 1'b0;
    repeat (W + 5) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand width; legal values are 8..64 and even.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start_i, input, 1 bit: request a new operation.
REQ-005 The block SHALL have port annul_i, input, 1 bit: abort the operation in progress.
REQ-006 The block SHALL have port op_i, input, 3 bits: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
REQ-007 The block SHALL have port a_i, input, WIDTH bits: multiplicand or dividend.
REQ-008 The block SHALL have port b_i, input, WIDTH bits: multiplier or divisor.
REQ-009 The block SHALL have port acc_i, input, 2*WIDTH bits: accumulator {hi,lo} for MADD/MSUB.
REQ-010 The block SHALL have port busy_o, output, 1 bit: operation in progress.
REQ-011 The block SHALL have port ready_o, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port result_o, output, 2*WIDTH bits: {hi,lo} result.
REQ-013 The block SHALL have port div_by_zero_o, output, 1 bit: last completed divide had b_i==0.

Function
REQ-014 The FSM SHALL have states IDLE, MUL, DIV, DONE.
REQ-015 An operation SHALL be accepted at a rising edge where state==IDLE, start_i==1 and annul_i==0; op_i, a_i, b_i and acc_i SHALL be captured at that edge only.
REQ-016 start_i in any state other than IDLE SHALL be ignored.
REQ-017 MUL ops SHALL use iterative shift-add on operand magnitudes, one bit per cycle, WIDTH iterations.
REQ-018 DIV ops SHALL use iterative restoring division on magnitudes, one quotient bit per cycle, WIDTH iterations.
REQ-019 After the WIDTH-th iteration edge the state SHALL become DONE; ready_o SHALL be 1 for exactly that one cycle; the next edge SHALL return to IDLE.
REQ-020 busy_o SHALL be 1 in MUL, DIV and DONE; busy_o SHALL be 0 in IDLE.
REQ-021 Signed MULT SHALL produce the two's-complement 2*WIDTH product of the signed operands.
REQ-022 DIV SHALL place the quotient in lo and the remainder in hi.
REQ-023 A DIV quotient SHALL be negative iff the operand signs differ, and the remainder sign SHALL follow the dividend.
REQ-024 DIV of most-negative by -1 SHALL yield lo = most-negative and hi = 0, with no flag.
REQ-025 DIV/DIVU with b_i==0 SHALL skip iteration: DONE next edge, result_o = 0, div_by_zero_o = 1.
REQ-026 Any other completion SHALL clear div_by_zero_o.
REQ-027 result_o and div_by_zero_o SHALL update only on entry to DONE and SHALL hold until the next completion.
REQ-028 annul_i==1 in MUL or DIV SHALL return the FSM to IDLE at the next edge with no ready_o pulse and result_o unchanged; annul_i in DONE SHALL be ignored.
REQ-029 Back-to-back: start_i held high SHALL be accepted in the IDLE cycle following DONE, giving a minimum issue interval of WIDTH+2 cycles.

Reset
REQ-030 While rst_i==1 the block SHALL force state IDLE, busy_o=0, ready_o=0, result_o=0, div_by_zero_o=0, and internal counters to 0.
REQ-031 Reset asserted mid-operation SHALL discard the operation with no ready_o pulse.

Configuration
REQ-032 The accumulate feature SHALL be controlled by macro MULDIV_ACCUMULATE_EN.
REQ-033 With MULDIV_ACCUMULATE_EN defined, MADD/MADDU SHALL give acc + product and MSUB/MSUBU SHALL give acc - product, modulo 2^(2*WIDTH), with the same latency as MULT.
REQ-034 Without MULDIV_ACCUMULATE_EN, op_i[2] SHALL be ignored (1xx behaves as 0xx), and acc_i SHALL remain a port but be unused.

Verification
REQ-035 WIDTH=32, MULT a=0xFFFFFFFE, b=3 -> ready_o pulses 32 edges after accept, result_o=0xFFFFFFFF_FFFFFFFA.
REQ-036 DIV a=0xFFFFFFF9, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_by_zero_o=0.
REQ-037 DIVU a=5, b=0 -> ready_o the cycle after accept edge +1, result_o=0, div_by_zero_o=1; following MULTU 2x3 -> result 6, div_by_zero_o=0.
REQ-038 MULTU start, annul_i at iteration 10 -> busy_o=0 next cycle, no ready_o, result_o keeps prior value.
REQ-039 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-040 MADD acc=0x10, a=4, b=5 -> result_o=0x24 with MULDIV_ACCUMULATE_EN, 0x14 without.
